// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 core: opcodes, instruction field positions
// and data widths.
package cpu8_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_CNT = 4;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB  = 7;
    localparam int unsigned OPC_LSB  = 4;
    localparam int unsigned ADDR_MSB = 3;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned RD_MSB   = 3;
    localparam int unsigned RD_LSB   = 2;
    localparam int unsigned RS1_MSB  = 3;
    localparam int unsigned RS1_LSB  = 2;
    localparam int unsigned RS2_MSB  = 1;
    localparam int unsigned RS2_LSB  = 0;
    localparam int unsigned RSST_MSB = 1;
    localparam int unsigned RSST_LSB = 0;

    // Opcodes; anything not listed executes as NOP
    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_LD   = 4'h4;
    localparam logic [OP_W-1:0] OP_ST   = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/cpu8_alu.sv
// Combinational ALU for cpu8.
// Ports: a, b - operands; op - opcode; y - result; c - carry (ADD) / borrow (SUB),
//        cleared for logic ops; z - y == 0; n - y[7].
module cpu8_alu
    import cpu8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              z,
    output logic              n
);

    logic [DATA_W:0] wide;

    // Nine-bit arithmetic: bit 8 is carry-out for ADD and borrow (a < b) for SUB
    always_comb begin
        wide = '0;
        y    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                y    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                y    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

    assign z = (y == '0);
    assign n = y[DATA_W-1];

endmodule

// File: rtl/cpu8.sv
// cpu8: single-cycle 8-bit accumulator-style core with internal instruction
// and data memories (loaded externally), four general registers and Z/C/N flags.
// Ports: clk - rising-edge clock; reset - synchronous active-high reset;
//        result - last ALU/LD value; zero, carry, negative - flags.
module cpu8
    import cpu8_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              negative
);

    localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    logic [DATA_W-1:0] instruction_memory [0:IMEM_DEPTH-1];
    logic [DATA_W-1:0] data_memory        [0:DMEM_DEPTH-1];
    logic [DATA_W-1:0] registers          [0:REG_CNT-1];
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] current_instruction;

    logic [OP_W-1:0]   opcode;
    logic [3:0]        addr;
    logic [1:0]        rd_ld, rs1, rs2, rs_st;
    logic [DATA_W-1:0] dmem_rdata;

    logic [DATA_W-1:0] alu_y;
    logic              alu_c, alu_z, alu_n;

    logic [DATA_W-1:0] pc_d, pc_inc;
    logic              reg_we;
    logic [1:0]        reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              dmem_we;
    logic [DATA_W-1:0] result_d;
    logic              zero_d, carry_d, negative_d;

    // Fetch and field decode
    assign current_instruction = instruction_memory[pc[IMEM_AW-1:0]];
    assign opcode     = current_instruction[OPC_MSB:OPC_LSB];
    assign addr       = current_instruction[ADDR_MSB:ADDR_LSB];
    assign rd_ld      = current_instruction[RD_MSB:RD_LSB];
    assign rs1        = current_instruction[RS1_MSB:RS1_LSB];
    assign rs2        = current_instruction[RS2_MSB:RS2_LSB];
    assign rs_st      = current_instruction[RSST_MSB:RSST_LSB];
    assign dmem_rdata = data_memory[addr[DMEM_AW-1:0]];

    // Sequential pc modulo the instruction memory depth
    assign pc_inc = (32'(pc) >= IMEM_DEPTH - 32'd1) ? '0 : pc + 8'd1;

    cpu8_alu u_alu (
        .a  (registers[rs1]),
        .b  (registers[rs2]),
        .op (opcode),
        .y  (alu_y),
        .c  (alu_c),
        .z  (alu_z),
        .n  (alu_n)
    );

    // Execute: next pc, register/memory write enables and flag updates
    always_comb begin
        pc_d       = pc_inc;
        reg_we     = 1'b0;
        reg_waddr  = 2'd3;
        reg_wdata  = alu_y;
        dmem_we    = 1'b0;
        result_d   = result;
        zero_d     = zero;
        carry_d    = carry;
        negative_d = negative;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                reg_we     = 1'b1;
                result_d   = alu_y;
                zero_d     = alu_z;
                carry_d    = alu_c;
                negative_d = alu_n;
            end
            OP_LD: begin
                reg_we     = 1'b1;
                reg_waddr  = rd_ld;
                reg_wdata  = dmem_rdata;
                result_d   = dmem_rdata;
                zero_d     = (dmem_rdata == '0);
                negative_d = dmem_rdata[DATA_W-1];
            end
            OP_ST:   dmem_we = 1'b1;
            OP_JMP:  pc_d = DATA_W'(addr);
            OP_JZ:   if (zero) pc_d = DATA_W'(addr);
            OP_HALT: pc_d = pc;
            default: pc_d = pc_inc;
        endcase
    end

    // Architectural state; memories are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) registers[i] <= '0;
        end else begin
            pc       <= pc_d;
            result   <= result_d;
            zero     <= zero_d;
            carry    <= carry_d;
            negative <= negative_d;
            if (reg_we) registers[reg_waddr] <= reg_wdata;
        end
    end

    // Data memory store port
    always_ff @(posedge clk) begin
        if (!reset && dmem_we) data_memory[addr[DMEM_AW-1:0]] <= registers[rs_st];
    end

endmodule

// File: tb/tb_cpu8.sv
// Testbench for cpu8: an ISA-level model pushes the expected architectural
// state each cycle; every test pops and compares after the edge.
module tb_cpu8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] result;
    logic       zero, carry, negative;

    cpu8 dut (
        .clk      (clk),
        .reset    (reset),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .negative (negative)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] regs;
        logic [7:0]  res;
        logic        z;
        logic        c;
        logic        n;
    } st_t;

    st_t sb_q[$];
    int  tests  = 0;
    int  failed = 0;

    // Reference model state
    logic [7:0] m_imem [16];
    logic [7:0] m_dmem [16];
    logic [7:0] m_r    [4];
    logic [7:0] m_pc   = 8'd0;
    logic [7:0] m_res  = 8'd0;
    logic       m_z = 1'b0, m_c = 1'b0, m_n = 1'b0;

    function automatic st_t dut_state();
        st_t s;
        s.pc   = dut.pc;
        s.regs = {dut.registers[3], dut.registers[2], dut.registers[1], dut.registers[0]};
        s.res  = result;
        s.z    = zero;
        s.c    = carry;
        s.n    = negative;
        return s;
    endfunction

    function automatic st_t model_state();
        st_t s;
        s.pc   = m_pc;
        s.regs = {m_r[3], m_r[2], m_r[1], m_r[0]};
        s.res  = m_res;
        s.z    = m_z;
        s.c    = m_c;
        s.n    = m_n;
        return s;
    endfunction

    task automatic put_i(input int a, input logic [7:0] v);
        dut.instruction_memory[a] = v;
        m_imem[a] = v;
    endtask

    task automatic put_d(input int a, input logic [7:0] v);
        dut.data_memory[a] = v;
        m_dmem[a] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            put_i(i, 8'h00);
            put_d(i, 8'h00);
        end
    endtask

    // Advance the model by one instruction and queue the expected state
    task automatic model_step();
        logic [7:0] ins, a, b, y, nxt;
        logic [8:0] w;
        logic       cy, alu;
        ins = m_imem[m_pc[3:0]];
        a   = m_r[ins[3:2]];
        b   = m_r[ins[1:0]];
        y   = 8'h00;
        cy  = 1'b0;
        alu = 1'b0;
        nxt = (m_pc + 8'd1) & 8'h0F;
        if (reset) begin
            m_pc = 8'd0; m_res = 8'd0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
            for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        end else begin
            case (ins[7:4])
                4'h2: begin w = {1'b0, a} + {1'b0, b}; y = w[7:0]; cy = w[8]; alu = 1'b1; end
                4'h3: begin y = a - b; cy = (a < b); alu = 1'b1; end
                4'h6: begin y = a & b; alu = 1'b1; end
                4'h7: begin y = a | b; alu = 1'b1; end
                4'h8: begin y = a ^ b; alu = 1'b1; end
                4'h4: begin
                    m_r[ins[3:2]] = m_dmem[ins[3:0]];
                    m_res = m_dmem[ins[3:0]];
                    m_z   = (m_res == 8'd0);
                    m_n   = m_res[7];
                end
                4'h5: m_dmem[ins[3:0]] = b;
                4'h9: nxt = {4'h0, ins[3:0]};
                4'hA: if (m_z) nxt = {4'h0, ins[3:0]};
                4'hF: nxt = m_pc;
                default: ;
            endcase
            if (alu) begin
                m_r[3] = y; m_res = y; m_c = cy; m_z = (y == 8'd0); m_n = y[7];
            end
            m_pc = nxt;
        end
        sb_q.push_back(model_state());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        sb_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        st_t got, e;
        clear_mem();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL reset_sb cyc%0d got %h exp %h", k, got, e); end
        end
        tests++;
        if ({dut.pc, result, zero, carry, negative} !== 19'd0) begin
            failed++; $display("FAIL reset_zero got pc=%h res=%h z%b c%b n%b exp 0", dut.pc, result, zero, carry, negative);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_add_store();
        st_t got, e;
        clear_mem();
        put_d(4, 8'd4); put_d(8, 8'd8);
        put_i(0, 8'h44); put_i(1, 8'h48); put_i(2, 8'h26); put_i(3, 8'h53);
        do_reset(2);
        for (int k = 0; k < 10; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL las_sb cyc%0d got %h exp %h", k, got, e); end
            if (k < 3) begin
                tests++;
                if (dut.pc !== 8'(k + 1)) begin failed++; $display("FAIL las_pc cyc%0d got %0d exp %0d", k, dut.pc, k + 1); end
            end
            if (k == 2) begin
                tests++;
                if ({result, zero, carry, negative} !== {8'd12, 3'b000}) begin
                    failed++; $display("FAIL las_add got res=%0d z%b c%b n%b exp 12/000", result, zero, carry, negative);
                end
            end
        end
        tests++;
        if ({dut.registers[1], dut.registers[2], dut.registers[3], dut.data_memory[3]} !== {8'd4, 8'd8, 8'd12, 8'd12}) begin
            failed++; $display("FAIL las_final got R1=%0d R2=%0d R3=%0d M3=%0d exp 4 8 12 12",
                               dut.registers[1], dut.registers[2], dut.registers[3], dut.data_memory[3]);
        end
    endtask

    task automatic test_carry_zero();
        st_t got, e;
        clear_mem();
        put_d(1, 8'hFF); put_d(4, 8'h01);
        put_i(0, 8'h41); put_i(1, 8'h44); put_i(2, 8'h21); put_i(3, 8'hF0);
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL cz_sb cyc%0d got %h exp %h", k, got, e); end
        end
        tests++;
        if ({dut.registers[3], zero, carry, negative} !== {8'h00, 3'b110}) begin
            failed++; $display("FAIL cz_flags got R3=%h z%b c%b n%b exp 00 z1 c1 n0", dut.registers[3], zero, carry, negative);
        end
    endtask

    task automatic test_borrow();
        st_t got, e;
        clear_mem();
        put_d(4, 8'd4); put_d(8, 8'd8);
        put_i(0, 8'h44); put_i(1, 8'h48); put_i(2, 8'h36); put_i(3, 8'hF0);
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL sub_sb cyc%0d got %h exp %h", k, got, e); end
        end
        tests++;
        if ({dut.registers[3], result, zero, carry, negative} !== {8'hFC, 8'hFC, 3'b011}) begin
            failed++; $display("FAIL sub_flags got R3=%h res=%h z%b c%b n%b exp FC FC z0 c1 n1",
                               dut.registers[3], result, zero, carry, negative);
        end
    endtask

    task automatic test_control();
        st_t got, e;
        logic [7:0] exp_pc [11];
        exp_pc = '{8'd1, 8'd5, 8'd6, 8'd7, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
        clear_mem();
        put_d(1, 8'h00); put_d(4, 8'h03);
        put_i(0, 8'h41); put_i(1, 8'hA5); put_i(5, 8'h44); put_i(6, 8'hA9);
        put_i(7, 8'h9A); put_i(10, 8'hF0);
        do_reset(1);
        for (int k = 0; k < 11; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL ctl_sb cyc%0d got %h exp %h", k, got, e); end
            tests++;
            if (dut.pc !== exp_pc[k]) begin failed++; $display("FAIL ctl_pc cyc%0d got %0d exp %0d", k, dut.pc, exp_pc[k]); end
        end
        tests++;
        if ({dut.registers[1], result, zero} !== {8'd3, 8'd3, 1'b0}) begin
            failed++; $display("FAIL ctl_halt got R1=%0d res=%0d z%b exp 3 3 0", dut.registers[1], result, zero);
        end
    endtask

    task automatic test_unknown();
        st_t got, e;
        clear_mem();
        put_d(4, 8'h77);
        put_i(0, 8'h44); put_i(1, 8'h00); put_i(2, 8'hC5); put_i(3, 8'hE3); put_i(4, 8'hB1);
        do_reset(1);
        for (int k = 0; k < 18; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL unk_sb cyc%0d got %h exp %h", k, got, e); end
            tests++;
            if (dut.pc !== 8'((k + 1) % 16)) begin failed++; $display("FAIL unk_pc cyc%0d got %0d exp %0d", k, dut.pc, (k + 1) % 16); end
        end
        tests++;
        if ({dut.registers[0], dut.registers[1], dut.registers[3], result, dut.data_memory[5]} !== {8'h00, 8'h77, 8'h00, 8'h77, 8'h00}) begin
            failed++; $display("FAIL unk_state got R0=%h R1=%h R3=%h res=%h M5=%h exp 00 77 00 77 00",
                               dut.registers[0], dut.registers[1], dut.registers[3], result, dut.data_memory[5]);
        end
    endtask

    task automatic test_reset_mid();
        st_t got, e;
        clear_mem();
        put_d(4, 8'd4); put_d(8, 8'd8); put_d(3, 8'hAA);
        put_i(0, 8'h44); put_i(1, 8'h48); put_i(2, 8'h26); put_i(3, 8'h53);
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL mid_sb cyc%0d got %h exp %h", k, got, e); end
        end
        // Reset lands while the ST at pc 3 is being fetched
        reset = 1'b1;
        tick();
        got = dut_state(); e = sb_q.pop_front(); tests++;
        if (got !== e) begin failed++; $display("FAIL mid_rst_sb got %h exp %h", got, e); end
        tests++;
        if ({dut.pc, result, zero, carry, negative, dut.registers[1], dut.registers[3]} !== 35'd0) begin
            failed++; $display("FAIL mid_rst_zero got pc=%h res=%h R1=%h R3=%h exp 0", dut.pc, result, dut.registers[1], dut.registers[3]);
        end
        tests++;
        if ({dut.data_memory[3], dut.data_memory[4], dut.instruction_memory[0], dut.instruction_memory[3]} !== {8'hAA, 8'h04, 8'h44, 8'h53}) begin
            failed++; $display("FAIL mid_mem got M3=%h M4=%h I0=%h I3=%h exp AA 04 44 53",
                               dut.data_memory[3], dut.data_memory[4], dut.instruction_memory[0], dut.instruction_memory[3]);
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            got = dut_state(); e = sb_q.pop_front(); tests++;
            if (got !== e) begin failed++; $display("FAIL mid_rerun_sb cyc%0d got %h exp %h", k, got, e); end
        end
        tests++;
        if ({dut.registers[3], dut.data_memory[3]} !== {8'd12, 8'd12}) begin
            failed++; $display("FAIL mid_rerun got R3=%0d M3=%0d exp 12 12", dut.registers[3], dut.data_memory[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        test_reset();
        test_load_add_store();
        test_carry_zero();
        test_borrow();
        test_control();
        test_unknown();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
